// File: rtl/col_reduce_array.sv
// col_reduce_array: 2-stage NPIX-pixel colour quantiser; settings swap only on start-of-frame beats.
// Defining COLRED_SWAP_GB_EN packs output pixels {R,B,G} instead of {R,G,B}.
module col_reduce_array #(
   parameter int NPIX = 2,
   parameter int CW   = 6,
   parameter int KW   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3*CW*NPIX-1:0]     in_data,
   input  logic                     in_sof,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [3*CW*NPIX-1:0]     out_data,
   output logic                     out_sof,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic [KW-1:0]            switch_vals,
   input  logic [1:0]               switch_sels,
   input  logic                     change
);
   localparam int PW = 3 * CW;
   localparam int DW = PW * NPIX;
   localparam logic [KW-1:0] CWK = KW'(CW);

   function automatic logic [CW-1:0] quant(input logic [CW-1:0] v, input logic [KW-1:0] k);
      logic [CW-1:0] one;
      one = CW'(1);
      return (k == '0 || k >= CWK) ? v : (v & ~({CW{1'b1}} >> k)) | (one << (CWK - KW'(1) - k));
   endfunction

   function automatic logic [PW-1:0] reduce_pix(input logic [PW-1:0] p, input logic [1:0] sel,
                                                input logic [KW-1:0] k);
      logic [CW-1:0] r, g, b;
      r = (sel == 2'd0 || sel == 2'd1) ? quant(p[3*CW-1:2*CW], k) : p[3*CW-1:2*CW];
      g = (sel == 2'd0 || sel == 2'd2) ? quant(p[2*CW-1:CW], k) : p[2*CW-1:CW];
      b = (sel == 2'd0 || sel == 2'd3) ? quant(p[CW-1:0], k) : p[CW-1:0];
`ifdef COLRED_SWAP_GB_EN
      return {r, b, g};
`else
      return {r, g, b};
`endif
   endfunction

   logic          en, acc, take_sw, take_pend;
   logic          pend_q, pend_d;
   logic [KW-1:0] pend_vals_q, pend_vals_d, act_keep_q, act_keep_d, s1_keep_q, s1_keep_d;
   logic [1:0]    pend_sels_q, pend_sels_d, act_sel_q, act_sel_d, s1_sel_q, s1_sel_d;
   logic          s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
   logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d;
   logic [DW-1:0] s1_data_q, s1_data_d, out_data_q, out_data_d, red;

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_data  = out_data_q;

   always_comb begin
      en          = !out_valid_q || out_ready;
      acc         = in_valid && en;
      // a change arriving with the sof beat bypasses the pending registers
      take_sw     = acc && in_sof && change;
      take_pend   = acc && in_sof && pend_q && !change;
      act_keep_d  = take_sw ? switch_vals : take_pend ? pend_vals_q : act_keep_q;
      act_sel_d   = take_sw ? switch_sels : take_pend ? pend_sels_q : act_sel_q;
      pend_d      = (take_sw || take_pend) ? 1'b0 : change ? 1'b1 : pend_q;
      pend_vals_d = change ? switch_vals : pend_vals_q;
      pend_sels_d = change ? switch_sels : pend_sels_q;
      s1_valid_d  = en ? in_valid : s1_valid_q;
      s1_sof_d    = en ? in_sof : s1_sof_q;
      s1_data_d   = en ? in_data : s1_data_q;
      s1_keep_d   = en ? act_keep_d : s1_keep_q;
      s1_sel_d    = en ? act_sel_d : s1_sel_q;
      red         = '0;
      for (int i = 0; i < NPIX; i++)
         red[PW*i +: PW] = reduce_pix(s1_data_q[PW*i +: PW], s1_sel_q, s1_keep_q);
      out_valid_d = en ? s1_valid_q : out_valid_q;
      out_sof_d   = en ? s1_sof_q : out_sof_q;
      out_data_d  = en ? red : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q      <= 1'b0;
         pend_vals_q <= '0;
         pend_sels_q <= '0;
         act_keep_q  <= '0;
         act_sel_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_data_q   <= '0;
         s1_keep_q   <= '0;
         s1_sel_q    <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_vals_q <= pend_vals_d;
         pend_sels_q <= pend_sels_d;
         act_keep_q  <= act_keep_d;
         act_sel_q   <= act_sel_d;
         s1_valid_q  <= s1_valid_d;
         s1_sof_q    <= s1_sof_d;
         s1_data_q   <= s1_data_d;
         s1_keep_q   <= s1_keep_d;
         s1_sel_q    <= s1_sel_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_col_reduce_array.sv
// tb_col_reduce_array: directed scoreboard bench for col_reduce_array (CW=6, NPIX=2, KW=3).
module tb_col_reduce_array;
   localparam int NPIX = 2;
   localparam int CW   = 6;
   localparam int KW   = 3;
   localparam int PW   = 3 * CW;
   localparam int DW   = PW * NPIX;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_sof = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_sof;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [KW-1:0] switch_vals = '0;
   logic [1:0]    switch_sels = '0;
   logic          change = 1'b0;

   int total = 0;
   int bad = 0;
   logic [DW:0] sb[$];

   // reference settings model
   logic          m_p = 1'b0;
   logic [KW-1:0] m_pv = '0, m_k = '0;
   logic [1:0]    m_ps = '0, m_s = '0;

   col_reduce_array #(.NPIX(NPIX), .CW(CW), .KW(KW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_sof(out_sof), .out_valid(out_valid),
      .out_ready(out_ready), .switch_vals(switch_vals), .switch_sels(switch_sels), .change(change)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] qm(input int v, input int k);
      if (k == 0 || k >= CW) return CW'(v);
      return CW'(((v >> (CW - k)) << (CW - k)) | (1 << (CW - k - 1)));
   endfunction

   function automatic logic [PW-1:0] pix(input int r, input int g, input int b);
      return {CW'(r), CW'(g), CW'(b)};
   endfunction

   function automatic logic [DW-1:0] rbeat();
      return {pix($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)),
              pix($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63))};
   endfunction

   function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] d);
      logic [DW-1:0] o;
      logic [PW-1:0] p;
      int r, g, b;
      o = '0;
      for (int i = 0; i < NPIX; i++) begin
         p = d[PW*i +: PW];
         r = int'(p[3*CW-1:2*CW]);
         g = int'(p[2*CW-1:CW]);
         b = int'(p[CW-1:0]);
         if (m_s == 0 || m_s == 1) r = int'(qm(r, int'(m_k)));
         if (m_s == 0 || m_s == 2) g = int'(qm(g, int'(m_k)));
         if (m_s == 0 || m_s == 3) b = int'(qm(b, int'(m_k)));
`ifdef COLRED_SWAP_GB_EN
         o[PW*i +: PW] = pix(r, b, g);
`else
         o[PW*i +: PW] = pix(r, g, b);
`endif
      end
      return o;
   endfunction

   task automatic send(input logic sof, input logic [DW-1:0] d, input logic chg = 1'b0,
                       input logic [KW-1:0] v = '0, input logic [1:0] s = '0);
      int n = 0;
      logic acc;
      in_sof = sof; in_data = d; in_valid = 1'b1;
      change = chg; switch_vals = v; switch_sels = s;
      do begin
         @(negedge clk);
         acc = in_ready;
         n++;
         @(posedge clk);
         if (acc && sof && chg) begin
            m_k = v; m_s = s; m_p = 1'b0;
         end else begin
            if (acc && sof && m_p) begin
               m_k = m_pv; m_s = m_ps; m_p = 1'b0;
            end
            if (chg) begin
               m_p = 1'b1; m_pv = v; m_ps = s;
            end
         end
         if (acc) sb.push_back({sof, exp_beat(d)});
         #1;
         change = 1'b0;
         chg = 1'b0;
      end while (!acc && n < 50);
      if (!acc) chk("send_timeout", '0, 1);
      in_valid = 1'b0;
      in_sof = 1'b0;
   endtask

   task automatic pulse(input logic [KW-1:0] v, input logic [1:0] s);
      change = 1'b1; switch_vals = v; switch_sels = s;
      @(posedge clk);
      m_p = 1'b1; m_pv = v; m_ps = s;
      #1 change = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_empty", {out_sof, out_data}, '0);
         else chk("beat", {out_sof, out_data}, sb.pop_front());
      end
   end

   initial begin
      logic [DW-1:0] d2d, d55;
      d2d = {pix(45, 45, 45), pix(45, 45, 45)};
      d55 = {pix('h2D, 'h2D, 'h2D), pix(45, 45, 45)};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", DW'(out_valid), 0);
      chk("rst_ready", DW'(in_ready), 1);
      chk("rst_data", {out_sof, out_data}, '0);
      @(posedge clk); #1 reset = 1'b1;

      send(1'b1, d2d);
      @(negedge clk);
      chk("lat_c1", DW'(out_valid), 0);
      @(negedge clk);
      chk("lat_c2", DW'(out_valid), 1);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) send(1'b0, rbeat());

      pulse(3'd2, 2'd0);
      send(1'b0, d55);
      send(1'b1, d55);
      send(1'b0, d55);
      send(1'b0, rbeat());

      pulse(3'd1, 2'd1);
      send(1'b0, d55);
      send(1'b0, rbeat());
      send(1'b1, d55);
      send(1'b0, rbeat());

      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(1'b0, rbeat());
         end
         begin
            int n = 0;
            logic [DW-1:0] hold;
            @(negedge clk);
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            hold = out_data;
            repeat (5) begin
               @(negedge clk);
               chk("bp_hold", {1'b0, out_data}, {1'b0, hold});
               chk("bp_ready", DW'(in_ready), 0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join

      send(1'b1, d55, 1'b1, 3'd3, 2'd2);
      send(1'b0, rbeat());
      send(1'b1, d55);
      send(1'b0, d55);
      reset = 1'b0;
      sb.delete();
      m_p = 1'b0; m_k = '0; m_s = '0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", DW'(out_valid), 0);
      @(posedge clk); #1 reset = 1'b1;
      send(1'b1, d55);
      send(1'b0, {pix(1, 2, 3), pix(1, 2, 3)});
      send(1'b1, {pix(63, 0, 32), pix(1, 2, 3)});

      for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
      chk("drain", DW'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
